// File: rtl/lsu_pkg.sv
// Shared types and byte-lane helpers for the load/store unit.
// Lanes are big-endian: byte offset 0 is the most significant byte of the word.
package lsu_pkg;

  typedef enum logic [2:0] {
    LSU_LB  = 3'd0,
    LSU_LBU = 3'd1,
    LSU_LH  = 3'd2,
    LSU_LHU = 3'd3,
    LSU_LW  = 3'd4,
    LSU_SB  = 3'd5,
    LSU_SH  = 3'd6,
    LSU_SW  = 3'd7
  } lsu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_RMW_RD,
    ST_RMW_MERGE,
    ST_WR,
    ST_DONE
  } lsu_state_t;

  localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
  localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

  // Right-shift that brings byte lane `off` down to bits [7:0].
  function automatic logic [4:0] byteShift(input logic [1:0] off);
    return {~off, 3'b000};
  endfunction

  function automatic logic [4:0] halfShift(input logic off1);
    return {~off1, 4'b0000};
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: extracts and extends load data, and merges
// byte/halfword store data into a previously read word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  lsu_op_t     i_op,
  input  logic [1:0]  i_byteOff,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_loadData,
  output logic [31:0] o_storeWord
);

  logic [4:0]  w_bShift;
  logic [4:0]  w_hShift;
  logic [31:0] w_byteWord;
  logic [31:0] w_halfWord;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_bShift   = byteShift(i_byteOff);
  assign w_hShift   = halfShift(i_byteOff[1]);
  assign w_byteWord = i_word >> w_bShift;
  assign w_halfWord = i_word >> w_hShift;
  assign w_byte     = w_byteWord[7:0];
  assign w_half     = w_halfWord[15:0];

  always_comb begin
    o_loadData = i_word;
    case (i_op)
      LSU_LB:  o_loadData = {{24{w_byte[7]}}, w_byte};
      LSU_LBU: o_loadData = {24'h000000, w_byte};
      LSU_LH:  o_loadData = {{16{w_half[15]}}, w_half};
      LSU_LHU: o_loadData = {16'h0000, w_half};
      default: o_loadData = i_word;
    endcase
  end

  // Sub-word stores keep every lane of the old word except the target one.
  always_comb begin
    o_storeWord = i_wdata;
    case (i_op)
      LSU_SB:  o_storeWord = (i_word & ~(BYTE_MASK << w_bShift)) |
                             ((i_wdata & BYTE_MASK) << w_bShift);
      LSU_SH:  o_storeWord = (i_word & ~(HALF_MASK << w_hShift)) |
                             ((i_wdata & HALF_MASK) << w_hShift);
      default: o_storeWord = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: turns one byte-addressed load/store at a time into
// word-level read, write or read-modify-write cycles on data_memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 32
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err_misaligned,
  output logic        err_range,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] mem_read_data
);

  lsu_state_t  r_state;
  lsu_state_t  w_nextState;
  lsu_op_t     r_op;
  lsu_op_t     w_reqOp;
  logic [1:0]  r_byteOff;
  logic [31:0] r_wdata;
  logic [31:0] r_memAddr;
  logic [31:0] r_memWdata;
  logic [31:0] r_rdata;
  logic        r_errMis;
  logic        r_errRange;
  logic        w_accept;
  logic        w_misaligned;
  logic        w_outOfRange;
  logic [31:0] w_loadData;
  logic [31:0] w_storeWord;

  assign w_reqOp  = lsu_op_t'(req_op);
  assign w_accept = req_valid && (r_state == ST_IDLE);

  assign w_misaligned =
      (((w_reqOp == LSU_LH) || (w_reqOp == LSU_LHU) || (w_reqOp == LSU_SH)) && req_addr[0]) ||
      (((w_reqOp == LSU_LW) || (w_reqOp == LSU_SW)) && (req_addr[1:0] != 2'b00));
  assign w_outOfRange = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);

  lsu_lane_align u_laneAlign (
    .i_op        (r_op),
    .i_byteOff   (r_byteOff),
    .i_word      (mem_read_data),
    .i_wdata     (r_wdata),
    .o_loadData  (w_loadData),
    .o_storeWord (w_storeWord)
  );

  always_ff @(posedge Clock) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  // Erroring requests skip straight to DONE so they never touch memory.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_misaligned || w_outOfRange)                  w_nextState = ST_DONE;
          else if (w_reqOp == LSU_SW)                        w_nextState = ST_WR;
          else if ((w_reqOp == LSU_SB) || (w_reqOp == LSU_SH)) w_nextState = ST_RMW_RD;
          else                                               w_nextState = ST_RD;
        end
      end
      ST_RD:        w_nextState = ST_RD_WAIT;
      ST_RD_WAIT:   w_nextState = ST_DONE;
      ST_RMW_RD:    w_nextState = ST_RMW_MERGE;
      ST_RMW_MERGE: w_nextState = ST_WR;
      ST_WR:        w_nextState = ST_DONE;
      ST_DONE:      w_nextState = ST_IDLE;
      default:      w_nextState = ST_IDLE;
    endcase
  end

  // r_memWdata doubles as the merged-word register for sub-word stores.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_op       <= LSU_LB;
      r_byteOff  <= 2'b00;
      r_wdata    <= 32'h0;
      r_memAddr  <= 32'h0;
      r_memWdata <= 32'h0;
      r_rdata    <= 32'h0;
      r_errMis   <= 1'b0;
      r_errRange <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op       <= w_reqOp;
        r_byteOff  <= req_addr[1:0];
        r_wdata    <= req_wdata;
        r_memAddr  <= {2'b00, req_addr[31:2]};
        r_errMis   <= w_misaligned;
        r_errRange <= w_outOfRange;
        if (w_reqOp == LSU_SW) r_memWdata <= req_wdata;
      end
      if (r_state == ST_RD_WAIT)   r_rdata    <= w_loadData;
      if (r_state == ST_RMW_MERGE) r_memWdata <= w_storeWord;
    end
  end

  assign req_ready      = (r_state == ST_IDLE);
  assign done           = (r_state == ST_DONE);
  assign err_misaligned = done && r_errMis;
  assign err_range      = done && r_errRange;
  assign MemRead        = (r_state == ST_RD) || (r_state == ST_RMW_RD);
  assign MemWrite       = (r_state == ST_WR);
  assign mem_address    = r_memAddr;
  assign mem_write_data = r_memWdata;
  assign rdata          = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a simple
// synchronous-read word memory standing in for data_memory.
module tb_load_store_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        done;
  logic [31:0] rdata;
  logic        err_misaligned;
  logic        err_range;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:31];
  logic        tbWrEn = 1'b0;
  logic [4:0]  tbWrAddr = 5'd0;
  logic [31:0] tbWrData = 32'h0;

  int numChecks = 0;
  int numFails  = 0;

  // Results of the most recent runOp call.
  int          doneCyc, nRd, nWr, wrCyc, busyReady, bothStrobes;
  logic [31:0] wrAddr, wrData;
  logic        misFlag, rngFlag;

  localparam logic [2:0] OP_LB = 3'd0, OP_LBU = 3'd1, OP_LH = 3'd2, OP_LHU = 3'd3,
                         OP_LW = 3'd4, OP_SB = 3'd5, OP_SH = 3'd6, OP_SW = 3'd7;

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (tbWrEn)   mem[tbWrAddr] <= tbWrData;
    if (MemWrite) mem[mem_address[4:0]] <= mem_write_data;
    mem_read_data <= mem[mem_address[4:0]];
  end

  load_store_unit #(.MEM_WORDS(32)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .done           (done),
    .rdata          (rdata),
    .err_misaligned (err_misaligned),
    .err_range      (err_range),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .MemWrite       (MemWrite),
    .MemRead        (MemRead),
    .mem_read_data  (mem_read_data)
  );

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    tbWrEn = 1'b1; tbWrAddr = a; tbWrData = d;
    tick;
    tbWrEn = 1'b0;
  endtask

  // Issues one request from IDLE and records strobes/latency until done (bounded).
  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    doneCyc = -1; nRd = 0; nWr = 0; wrCyc = -1; busyReady = 0; bothStrobes = 0;
    wrAddr = 32'hX; wrData = 32'hX; misFlag = 1'b0; rngFlag = 1'b0;
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d;
    tick;
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (req_ready) busyReady++;
      if (MemRead && MemWrite) bothStrobes++;
      if (MemRead) nRd++;
      if (MemWrite) begin
        nWr++; wrAddr = mem_address; wrData = mem_write_data; wrCyc = cyc;
      end
      if (done) begin
        doneCyc = cyc; misFlag = err_misaligned; rngFlag = err_range;
        tick;
        break;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    tick; tick;
    if (req_ready !== 1'b1) begin numFails++; $display("[TB] FAIL reset_ready got=%b exp=1", req_ready); end
    numChecks++;
    if ({done, err_misaligned, err_range, MemRead, MemWrite} !== 5'b0) begin
      numFails++; $display("[TB] FAIL reset_flags got=%b exp=00000", {done, err_misaligned, err_range, MemRead, MemWrite});
    end
    numChecks++;
    if ({rdata, mem_address, mem_write_data} !== 96'h0) begin
      numFails++; $display("[TB] FAIL reset_data got=%h/%h/%h exp=0", rdata, mem_address, mem_write_data);
    end
    numChecks++;
    Reset = 1'b0;
    tick;
  endtask

  task automatic test_word;
    runOp(OP_SW, 32'h14, 32'hDEADBEEF);
    if (doneCyc !== 2) begin numFails++; $display("[TB] FAIL sw_latency got=%0d exp=2", doneCyc); end
    numChecks++;
    if (wrCyc !== 1 || nWr !== 1 || nRd !== 0) begin
      numFails++; $display("[TB] FAIL sw_strobes got=wrCyc%0d nWr%0d nRd%0d exp=1/1/0", wrCyc, nWr, nRd);
    end
    numChecks++;
    if (wrAddr !== 32'd5 || wrData !== 32'hDEADBEEF) begin
      numFails++; $display("[TB] FAIL sw_bus got=%h/%h exp=5/deadbeef", wrAddr, wrData);
    end
    numChecks++;
    if (busyReady !== 0) begin numFails++; $display("[TB] FAIL sw_busy_ready got=%0d exp=0", busyReady); end
    numChecks++;
    runOp(OP_LW, 32'h14, 32'h0);
    if (doneCyc !== 3 || nRd !== 1 || nWr !== 0) begin
      numFails++; $display("[TB] FAIL lw_timing got=done%0d nRd%0d nWr%0d exp=3/1/0", doneCyc, nRd, nWr);
    end
    numChecks++;
    if (rdata !== 32'hDEADBEEF) begin numFails++; $display("[TB] FAIL lw_rdata got=%h exp=deadbeef", rdata); end
    numChecks++;
    // Highest legal word (index 31) must not be flagged out of range.
    preload(5'd31, 32'hA5A5_0F0F);
    runOp(OP_LW, 32'h7C, 32'h0);
    if (rdata !== 32'hA5A50F0F || rngFlag !== 1'b0 || doneCyc !== 3) begin
      numFails++; $display("[TB] FAIL lw_last_word got=%h rng=%b done=%0d exp=a5a50f0f/0/3", rdata, rngFlag, doneCyc);
    end
    numChecks++;
  endtask

  task automatic test_subword_loads;
    logic [2:0]  ops [5] = '{OP_LB, OP_LBU, OP_LB, OP_LH, OP_LHU};
    logic [31:0] adr [5] = '{32'h0, 32'h0, 32'h2, 32'h2, 32'h0};
    logic [31:0] exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F, 32'h00007F01, 32'h000080FF};
    preload(5'd0, 32'h80FF7F01);
    for (int i = 0; i < 5; i++) begin
      runOp(ops[i], adr[i], 32'h0);
      if (rdata !== exp[i] || doneCyc !== 3) begin
        numFails++; $display("[TB] FAIL load_ext[%0d] got=%h done=%0d exp=%h/3", i, rdata, doneCyc, exp[i]);
      end
      numChecks++;
    end
  endtask

  task automatic test_rmw;
    preload(5'd3, 32'h11223344);
    runOp(OP_SB, 32'hD, 32'h000000AB);
    if (doneCyc !== 4 || nRd !== 1 || nWr !== 1 || bothStrobes !== 0) begin
      numFails++; $display("[TB] FAIL sb_timing got=done%0d nRd%0d nWr%0d both%0d exp=4/1/1/0", doneCyc, nRd, nWr, bothStrobes);
    end
    numChecks++;
    if (wrData !== 32'h11AB3344 || mem[3] !== 32'h11AB3344) begin
      numFails++; $display("[TB] FAIL sb_merge got=%h mem=%h exp=11ab3344", wrData, mem[3]);
    end
    numChecks++;
    runOp(OP_SH, 32'hE, 32'h0000CAFE);
    if (mem[3] !== 32'h11ABCAFE || wrAddr !== 32'd3) begin
      numFails++; $display("[TB] FAIL sh_merge got=%h addr=%h exp=11abcafe/3", mem[3], wrAddr);
    end
    numChecks++;
    if (rdata !== 32'h000080FF) begin numFails++; $display("[TB] FAIL store_keeps_rdata got=%h exp=000080ff", rdata); end
    numChecks++;
  endtask

  task automatic test_errors;
    logic [2:0]  ops [4] = '{OP_LW, OP_SH, OP_SW, OP_LW};
    logic [31:0] adr [4] = '{32'h6, 32'h3, 32'h80, 32'h81};
    logic [1:0]  exp [4] = '{2'b10, 2'b10, 2'b01, 2'b11};
    for (int i = 0; i < 4; i++) begin
      runOp(ops[i], adr[i], 32'h12345678);
      if ({misFlag, rngFlag} !== exp[i] || doneCyc !== 1 || nRd !== 0 || nWr !== 0) begin
        numFails++; $display("[TB] FAIL err[%0d] got=flags%b done%0d nRd%0d nWr%0d exp=%b/1/0/0",
                             i, {misFlag, rngFlag}, doneCyc, nRd, nWr, exp[i]);
      end
      numChecks++;
    end
    if (rdata !== 32'h000080FF || mem[3] !== 32'h11ABCAFE) begin
      numFails++; $display("[TB] FAIL err_side_effects got=%h/%h exp=000080ff/11abcafe", rdata, mem[3]);
    end
    numChecks++;
  endtask

  task automatic test_reset_mid;
    preload(5'd4, 32'h55667788);
    req_valid = 1'b1; req_op = OP_SB; req_addr = 32'h10; req_wdata = 32'h99;
    tick;
    req_valid = 1'b0;
    tick;
    Reset = 1'b1;
    tick;
    if (req_ready !== 1'b1 || {done, err_misaligned, err_range, MemRead, MemWrite} !== 5'b0) begin
      numFails++; $display("[TB] FAIL midreset_ctrl got=ready%b flags%b exp=1/00000", req_ready,
                           {done, err_misaligned, err_range, MemRead, MemWrite});
    end
    numChecks++;
    if ({rdata, mem_address, mem_write_data} !== 96'h0) begin
      numFails++; $display("[TB] FAIL midreset_data got=%h/%h/%h exp=0", rdata, mem_address, mem_write_data);
    end
    numChecks++;
    Reset = 1'b0;
    runOp(OP_LW, 32'h10, 32'h0);
    if (rdata !== 32'h55667788 || doneCyc !== 3 || mem[4] !== 32'h55667788) begin
      numFails++; $display("[TB] FAIL midreset_mem got=%h mem=%h done=%0d exp=55667788/3", rdata, mem[4], doneCyc);
    end
    numChecks++;
  endtask

  task automatic test_back_to_back;
    logic [2:0]  ops [3] = '{OP_SW, OP_LW, OP_LBU};
    logic [31:0] adr [3] = '{32'h20, 32'h20, 32'h23};
    logic [11:0] readyVec = '0;
    logic [11:0] doneVec  = '0;
    logic [31:0] lwData   = 32'h0;
    int          idx      = 0;
    int          accepts  = 0;
    logic        acc;
    req_valid = 1'b1; req_op = ops[0]; req_addr = adr[0]; req_wdata = 32'h01020304;
    for (int cyc = 0; cyc < 12; cyc++) begin
      readyVec[cyc] = req_ready;
      doneVec[cyc]  = done;
      if (done && cyc == 6) lwData = rdata;
      acc = req_ready && req_valid;
      tick;
      if (acc) begin
        accepts++;
        idx++;
        if (idx < 3) begin req_op = ops[idx]; req_addr = adr[idx]; end
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    if (accepts !== 3 || readyVec !== 12'b1000_1000_1001) begin
      numFails++; $display("[TB] FAIL b2b_accepts got=%0d ready=%b exp=3/100010001001", accepts, readyVec);
    end
    numChecks++;
    if (doneVec !== 12'b0100_0100_0100) begin
      numFails++; $display("[TB] FAIL b2b_done got=%b exp=010001000100", doneVec);
    end
    numChecks++;
    if (lwData !== 32'h01020304 || rdata !== 32'h00000004 || mem[8] !== 32'h01020304) begin
      numFails++; $display("[TB] FAIL b2b_data got=%h/%h/%h exp=01020304/00000004/01020304", lwData, rdata, mem[8]);
    end
    numChecks++;
  endtask

  initial begin
    test_reset;
    test_word;
    test_subword_loads;
    test_rmw;
    test_errors;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage between the execute stage and the word-addressed `data_memory`. It accepts one load/store request at a time carrying a byte address, checks alignment and range, and converts it into word-level `MemRead`/`MemWrite` cycles. Byte and halfword loads are sign- or zero-extended. Byte and halfword stores are done as read-modify-write, because the memory only writes whole words.

## Interface
Parameters:
- MEM_WORDS, 32, memory depth in words; valid word index range is 0..MEM_WORDS-1

Ports:
- Clock  in  1  sole clock, rising edge
- Reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted at a rising edge where req_valid && req_ready
- req_op  in  3  operation code (lsu_pkg)
- req_addr  in  32  byte address
- req_wdata  in  32  store data; the low 8 or 16 bits are used for SB/SH
- done  out  1  one-cycle pulse marking completion
- rdata  out  32  load result; holds until the next successful load
- err_misaligned  out  1  valid with done
- err_range  out  1  valid with done
- mem_address  out  32  word index to data_memory = {2'b0, addr[31:2]}
- mem_write_data  out  32  word to data_memory
- MemWrite  out  1  memory write strobe
- MemRead  out  1  memory read strobe
- mem_read_data  in  32  data_memory read_data; valid the cycle after the MemRead cycle

## Operation
- Ops: LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7.
- Byte lanes are big-endian.
  - Byte offset b selects bits [31-8b -: 8].
  - Halfword offset 0 selects [31:16]; offset 2 selects [15:0].
- On accept, latch op, addr and wdata, then compute the checks:
  - misaligned = (LH/LHU/SH && addr[0]) || (LW/SW && addr[1:0]!=0)
  - range = addr[31:2] >= MEM_WORDS
  - Both flags are reported independently.
- FSM states: IDLE, RD, RD_WAIT, RMW_RD, RMW_MERGE, WR, DONE.
  - IDLE: on accept, any error goes to DONE; loads go to RD; SW goes to WR; SB/SH go to RMW_RD.
  - RD: MemRead=1, then RD_WAIT.
  - RD_WAIT: extract the lane and sign/zero-extend into rdata, then DONE.
  - RMW_RD: MemRead=1, then RMW_MERGE.
  - RMW_MERGE: replace the target lane of mem_read_data with wdata[7:0] or [15:0], register the merged word, then WR.
  - WR: MemWrite=1 with mem_write_data = the merged word (SB/SH) or wdata (SW), then DONE.
  - DONE: done=1 and error flags driven, then IDLE.
- An erroring request never asserts MemRead or MemWrite, and rdata is unchanged.
- A store never modifies rdata.
- MemRead and MemWrite are never high together and are decoded from the state register.
- The memory is never accessed outside the latched request.

## Timing
- Counting cycles after the accept edge, done is high in:
  - cycle 1 for an error
  - cycle 2 for SW
  - cycle 3 for loads
  - cycle 4 for SB/SH
- Back-to-back: the next accept is possible in the IDLE cycle following DONE, so the minimum initiation interval is latency+1.
- req_valid while busy is ignored. The requester holds the request until it is accepted.
- mem_address is registered and stable for the whole operation, from the cycle after accept through DONE.
- Reset values:
  - state IDLE, req_ready=1
  - done=0, rdata=0, both error flags 0
  - MemRead=0, MemWrite=0
  - mem_address=0, mem_write_data=0
- Reset mid-operation: the FSM goes to IDLE at the reset edge and the operation is dropped.
  - Exception: if the reset edge coincides with the WR cycle, the memory still captures that write, since the memory has no reset.
  - A reset during RMW_RD or RMW_MERGE leaves memory untouched.
- Reads take one MemRead cycle. mem_read_data is sampled only in RD_WAIT or RMW_MERGE.

## Structure
- Package lsu_pkg holds:
  - op encodings LSU_LB..LSU_SW as a 3-bit typedef
  - the FSM state enum
  - byte-lane helper constants
- Sub-module lsu_lane_align is purely combinational, with inputs op, addr[1:0], word and wdata. It outputs the extended load value and the merged store word.
- The FSM and registers live in load_store_unit.

## Test plan
- SW addr 0x14, data 0xDEADBEEF, then LW 0x14 → MemWrite in the 1st cycle after accept with mem_address=5; done in cycle 2; LW returns rdata=0xDEADBEEF with done in cycle 3.
- Word 0 = 0x80FF7F01:
  - LB 0x0 → 0xFFFFFF80
  - LBU 0x0 → 0x00000080
  - LB 0x2 → 0x0000007F
  - LH 0x2 → 0x00007F01
  - LHU 0x0 → 0x000080FF
- Word 3 = 0x11223344, SB 0xD addr with wdata 0xAB → one MemRead then one MemWrite with data 0x11AB3344; done in cycle 4. Then SH 0xE with wdata 0xCAFE → 0x11ABCAFE.
- LW 0x6, SH 0x3, and SW 0x80 with MEM_WORDS=32:
  - LW 0x6 and SH 0x3 → err_misaligned=1.
  - SW 0x80 → err_range=1.
  - All three complete with done in cycle 1, no MemRead/MemWrite, rdata unchanged.
- SB in flight, Reset asserted during RMW_MERGE → memory word unchanged, FSM in IDLE, all outputs at reset values the cycle after the reset edge; a new request is accepted immediately.
- req_valid held high continuously with 3 queued ops → exactly one accept per IDLE cycle, no request is lost or duplicated, and req_ready=0 from the cycle after accept through DONE.
